// File: rtl/spine_egress_scheduler_pkg.sv
// spine_egress_scheduler_pkg: shared NoC constants, requester indices and scheduler state encoding
package noc_pkg;
  localparam int DWIDTH_DEF = 16;
  localparam int DEST_MSB = 15;
  localparam int DEST_LSB = 10;
  localparam int NUM_SPINE = 4;
  localparam int REQ_GPU = 0;
  localparam int REQ_SP1 = 1;
  localparam int REQ_SP2 = 2;
  localparam int REQ_SP3 = 3;
  localparam int REQ_SP4 = 4;
  localparam logic [0:0] SCH_IDLE = 1'b0;
  localparam logic [0:0] SCH_LOCK = 1'b1;
  function automatic int rr_wrap(input int a, input int n);
    return a >= n ? a - n : a;
  endfunction
endpackage

// File: rtl/spine_egress_scheduler_if.sv
// spine_egress_scheduler_if: requester flits, egress flit, credit return and scheduler status
interface spine_egress_scheduler_if #(
  parameter int NUM_REQ = 5,
  parameter int DWIDTH = noc_pkg::DWIDTH_DEF
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ*DWIDTH-1:0] req_data;
  logic [NUM_REQ-1:0] req_ready;
  logic [DWIDTH-1:0] out_data;
  logic out_valid;
  logic credit_return;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [3:0] credit_cnt;
  logic busy;
  logic credit_err;
  modport master (
    output req_valid, req_last, req_data, credit_return,
    input req_ready, out_data, out_valid, grant_onehot, credit_cnt, busy, credit_err
  );
  modport slave (
    input req_valid, req_last, req_data, credit_return,
    output req_ready, out_data, out_valid, grant_onehot, credit_cnt, busy, credit_err
  );
endinterface

// File: rtl/spine_egress_scheduler_arb.sv
// rr_arbiter: combinational rotating-priority pick starting at ptr, wrapping mod N
module rr_arbiter import noc_pkg::*; #(
  parameter int N = 5
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt_onehot,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);
  localparam int IW = $clog2(N);
  always_comb begin
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[rr_wrap(int'(ptr) + k, N)]) gnt_idx = IW'(rr_wrap(int'(ptr) + k, N));
  end
  assign any = |req;
  assign gnt_onehot = any ? N'(1) << gnt_idx : '0;
endmodule

// File: rtl/spine_egress_scheduler.sv
// spine_egress_scheduler: round-robin, credit-gated egress link scheduler holding a grant per packet
module spine_egress_scheduler import noc_pkg::*; #(
  parameter int NUM_REQ = 5,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int CREDITS = 4,
  parameter int MAX_BURST = 4
) (
  input logic ACLK,
  input logic ARESETn,
  spine_egress_scheduler_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  logic [0:0] state;
  logic [IW-1:0] owner, rr_ptr, arb_idx;
  logic [NUM_REQ-1:0] arb_onehot, grant;
  logic arb_any, credit_ok, xfer, release_now, out_valid, credit_err;
  logic [3:0] burst_cnt, credit_cnt;
  logic [DWIDTH-1:0] owner_data, out_data;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req(bus.req_valid), .ptr(rr_ptr), .gnt_onehot(arb_onehot), .gnt_idx(arb_idx), .any(arb_any)
  );
  assign credit_ok = credit_cnt != 4'd0;
  assign bus.req_ready = (state == SCH_LOCK && credit_ok) ? grant : '0;
  assign xfer = |(bus.req_valid & bus.req_ready);
  assign owner_data = bus.req_data[int'(owner)*DWIDTH +: DWIDTH];
  assign release_now = xfer && (bus.req_last[owner] || burst_cnt == 4'(MAX_BURST - 1));
  assign bus.out_data = out_data;
  assign bus.out_valid = out_valid;
  assign bus.grant_onehot = grant;
  assign bus.credit_cnt = credit_cnt;
  assign bus.busy = state == SCH_LOCK;
  assign bus.credit_err = credit_err;
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state <= SCH_IDLE;
      grant <= '0;
      owner <= '0;
      rr_ptr <= '0;
      burst_cnt <= '0;
      credit_cnt <= 4'(CREDITS);
      credit_err <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      out_valid <= xfer;
      if (xfer) out_data <= owner_data;
      // a return and a transfer in the same cycle cancel out
      if (xfer && !bus.credit_return) credit_cnt <= credit_cnt - 4'd1;
      else if (!xfer && bus.credit_return) begin
        if (credit_cnt == 4'(CREDITS)) credit_err <= 1'b1;
        else credit_cnt <= credit_cnt + 4'd1;
      end
      if (state == SCH_IDLE) begin
        if (arb_any && credit_ok) begin
          state <= SCH_LOCK;
          owner <= arb_idx;
          grant <= arb_onehot;
        end
      end else if (release_now) begin
        state <= SCH_IDLE;
        grant <= '0;
        burst_cnt <= '0;
        rr_ptr <= owner == IW'(NUM_REQ - 1) ? '0 : owner + 1'b1;
      end else if (xfer) burst_cnt <= burst_cnt + 4'd1;
    end
  end
endmodule

// File: tb/tb_spine_egress_scheduler.sv
// tb_spine_egress_scheduler: queue-fed sources, scoreboard of expected egress flits, direct status checks
module tb_spine_egress_scheduler;
  typedef struct packed {logic [15:0] d; logic l;} flit_t;
  logic clk = 0, rst_n = 0, cr_auto = 0, cr_man = 0, cr_q = 0;
  logic [4:0] fired = '0, last_g = '0;
  int checks = 0, errors = 0, rx = 0, rx0 = 0, n = 0;
  logic [15:0] exp_q[$];
  logic [4:0] gq[$];
  flit_t srcq[5][$];
  spine_egress_scheduler_if #(.NUM_REQ(5), .DWIDTH(16)) bus ();
  spine_egress_scheduler #(.NUM_REQ(5), .DWIDTH(16), .CREDITS(4), .MAX_BURST(4)) dut (
    .ACLK(clk), .ARESETn(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.credit_return = cr_q | cr_man;
  always @(posedge clk) begin
    fired <= bus.req_valid & bus.req_ready & {5{rst_n}};
    cr_q <= rst_n & cr_auto & bus.out_valid;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    logic [4:0] v, l;
    logic [79:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < 5; i++) begin
      if (fired[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      if (srcq[i].size() > 0) begin
        v[i] = 1'b1;
        l[i] = srcq[i][0].l;
        d[i*16 +: 16] = srcq[i][0].d;
      end
    end
    bus.req_valid = v;
    bus.req_last = l;
    bus.req_data = d;
  end
  always @(negedge clk) begin
    logic [15:0] e;
    if (bus.out_valid) begin
      rx++;
      e = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk("flit", 32'(bus.out_data), 32'(e));
    end
  end
  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
      if (bus.grant_onehot != 0 && last_g == 0) gq.push_back(bus.grant_onehot);
      last_g = bus.grant_onehot;
    end
  endtask
  function automatic int src_left();
    int s = 0;
    for (int i = 0; i < 5; i++) s += srcq[i].size();
    return s;
  endfunction
  task automatic send(input int s, input logic [15:0] base, input int cnt);
    for (int k = 1; k <= cnt; k++) srcq[s].push_back(flit_t'{base + 16'(k), k == cnt});
  endtask
  task automatic drain(input string tag);
    int w = 0;
    while ((exp_q.size() > 0 || src_left() > 0) && w < 300) begin
      tick();
      w++;
    end
    chk(tag, exp_q.size(), 0);
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_last = '0;
    bus.req_data = '0;
    tick(3);
    rst_n = 1;
    tick(5);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_grant", bus.grant_onehot, 0);
    chk("rst_credit", bus.credit_cnt, 4);
    chk("rst_err", bus.credit_err, 0);
    chk("rst_busy", bus.busy, 0);
    send(2, 16'h0800, 3);
    exp_q.push_back(16'h0801);
    exp_q.push_back(16'h0802);
    exp_q.push_back(16'h0803);
    tick();
    chk("t2_grant", bus.grant_onehot, 5'b00100);
    chk("t2_ready", bus.req_ready, 5'b00100);
    chk("t2_bubble", bus.out_valid, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_out_valid", bus.out_valid, 1);
    end
    chk("t2_release", bus.grant_onehot, 0);
    tick();
    chk("t2_out_done", bus.out_valid, 0);
    chk("t2_idle", bus.busy, 0);
    chk("t2_credit", bus.credit_cnt, 1);
    cr_man = 1;
    tick(3);
    cr_man = 0;
    chk("t2_credit_back", bus.credit_cnt, 4);
    send(1, 16'h1000, 1);
    send(4, 16'h4000, 1);
    exp_q.push_back(16'h4001);
    exp_q.push_back(16'h1001);
    tick();
    chk("t2_rr_ptr3", bus.grant_onehot, 5'b10000);
    cr_auto = 1;
    drain("t2b_drain");
    rst_n = 0;
    tick();
    rst_n = 1;
    gq.delete();
    last_g = '0;
    for (int s = 0; s < 5; s++) begin
      send(s, 16'hA000 + 16'(s * 256), 1);
      exp_q.push_back(16'hA001 + 16'(s * 256));
    end
    srcq[0].push_back(flit_t'{16'hA002, 1'b1});
    exp_q.push_back(16'hA002);
    drain("t3_drain");
    begin
      logic [4:0] eg[6] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
      chk("t3_grant_cnt", gq.size(), 6);
      for (int k = 0; k < 6 && k < gq.size(); k++) chk("t3_grant_order", gq[k], eg[k]);
    end
    gq.delete();
    send(1, 16'h1100, 6);
    send(3, 16'h3300, 2);
    for (int k = 1; k <= 4; k++) exp_q.push_back(16'h1100 + 16'(k));
    exp_q.push_back(16'h3301);
    exp_q.push_back(16'h3302);
    exp_q.push_back(16'h1105);
    exp_q.push_back(16'h1106);
    drain("t4_drain");
    begin
      logic [4:0] eg[3] = '{5'b00010, 5'b01000, 5'b00010};
      chk("t4_grant_cnt", gq.size(), 3);
      for (int k = 0; k < 3 && k < gq.size(); k++) chk("t4_grant_order", gq[k], eg[k]);
    end
    cr_auto = 0;
    tick(3);
    chk("t5_credit_full", bus.credit_cnt, 4);
    rx0 = rx;
    send(0, 16'h0C00, 6);
    for (int k = 1; k <= 6; k++) exp_q.push_back(16'h0C00 + 16'(k));
    n = 0;
    while (rx < rx0 + 4 && n < 50) begin
      tick();
      n++;
    end
    tick(3);
    chk("t5_rx4", rx - rx0, 4);
    chk("t5_credit0", bus.credit_cnt, 0);
    chk("t5_ready0", bus.req_ready, 0);
    chk("t5_burst_release", bus.grant_onehot, 0);
    cr_man = 1;
    tick();
    cr_man = 0;
    tick(6);
    chk("t5_rx5", rx - rx0, 5);
    chk("t5_lock_held", bus.busy, 1);
    chk("t5_owner", bus.grant_onehot, 5'b00001);
    chk("t5_stall_ready", bus.req_ready, 0);
    chk("t5_stall_credit", bus.credit_cnt, 0);
    cr_man = 1;
    tick();
    cr_man = 0;
    drain("t5_drain");
    chk("t5_rx6", rx - rx0, 6);
    cr_man = 1;
    tick(4);
    cr_man = 0;
    chk("t6_credit_full", bus.credit_cnt, 4);
    chk("t6_no_err", bus.credit_err, 0);
    cr_man = 1;
    tick();
    cr_man = 0;
    chk("t6_err_set", bus.credit_err, 1);
    chk("t6_credit_held", bus.credit_cnt, 4);
    tick(3);
    chk("t6_err_sticky", bus.credit_err, 1);
    send(2, 16'h2A00, 3);
    exp_q.push_back(16'h2A01);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("t6_first_flit", bus.out_valid, 1);
    rst_n = 0;
    tick();
    chk("t6_rst_out_valid", bus.out_valid, 0);
    chk("t6_rst_out_data", bus.out_data, 0);
    chk("t6_rst_grant", bus.grant_onehot, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_credit", bus.credit_cnt, 4);
    chk("t6_rst_err", bus.credit_err, 0);
    srcq[2].delete();
    rst_n = 1;
    tick(3);
    chk("t6_dropped", bus.out_valid, 0);
    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
